// File: rtl/cpu_run_controller_if.sv
// Board-side control and status bundle between the run controller and the processor/display.
// Purely structural: no storage, no latency.
// No backpressure: levels and one-cycle pulses only.
interface cpu_run_controller_if #(
  parameter int DIV_WIDTH = 26,
  parameter int CNT_WIDTH = 16
);
  logic                 RunSw;
  logic                 StepBtn;
  logic [DIV_WIDTH-1:0] RateDiv;
  logic                 BpEnable;
  logic [31:0]          BpAddr;
  logic [31:0]          PCValue;
  logic                 CpuEn;
  logic                 Halted;
  logic                 BpHit;
  logic [CNT_WIDTH-1:0] InstrCount;

  // Controller side: reads switches/PC, drives enable and status.
  modport master (
    input  RunSw, StepBtn, RateDiv, BpEnable, BpAddr, PCValue,
    output CpuEn, Halted, BpHit, InstrCount
  );

  // Board/processor side.
  modport slave (
    output RunSw, StepBtn, RateDiv, BpEnable, BpAddr, PCValue,
    input  CpuEn, Halted, BpHit, InstrCount
  );
endinterface

// File: rtl/cpu_run_controller.sv
// Generates the single-cycle MIPS clock-enable: halt, free-run at RateDiv+1 cycles, single-step, PC breakpoint.
// All outputs registered; a step pulse appears two cycles after the button rises, a run pulse RateDiv+2 cycles after RunSw rises.
// No backpressure: the processor consumes every CpuEn pulse unconditionally.
module cpu_run_controller #(
  parameter int DIV_WIDTH = 26,
  parameter int CNT_WIDTH = 16
) (
  input logic                  Clk,
  input logic                  Rst,
  cpu_run_controller_if.master bus
);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_STEP  = 2'd1,
    S_RUN   = 2'd2,
    S_BREAK = 2'd3
  } state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state;
  logic [DIV_WIDTH-1:0] prescaler;
  logic                 step_q;
  logic                 first_pulse;
  logic                 cpu_en;
  logic                 halted;
  logic                 bp_hit;
  logic [CNT_WIDTH-1:0] instr_count;

  logic step_edge;
  logic pulse_due;
  logic bp_match;

  // A held button yields one edge; the breakpoint compares the PC the next pulse would execute.
  assign step_edge = bus.StepBtn & ~step_q;
  assign pulse_due = (prescaler == bus.RateDiv);
  assign bp_match  = bus.BpEnable && (bus.PCValue == bus.BpAddr);

  // Run/step sequencer with registered status outputs and a saturating pulse counter.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= S_HALT;
      prescaler   <= '0;
      step_q      <= 1'b0;
      first_pulse <= 1'b0;
      cpu_en      <= 1'b0;
      halted      <= 1'b1;
      bp_hit      <= 1'b0;
      instr_count <= '0;
    end else begin
      step_q <= bus.StepBtn;
      cpu_en <= 1'b0;

      // Count pulses as they complete; stick at all-ones rather than wrapping.
      if (cpu_en && (instr_count != '1)) begin
        instr_count <= instr_count + CNT_ONE;
      end

      case (state)
        S_HALT: begin
          if (bus.RunSw) begin
            // Entering RUN from any PC, including one sitting on the breakpoint,
            // must execute at least one instruction before a break can fire.
            state       <= S_RUN;
            prescaler   <= '0;
            first_pulse <= 1'b1;
            halted      <= 1'b0;
          end else if (step_edge) begin
            state <= S_STEP;
          end
        end

        S_STEP: begin
          // Exactly one instruction; breakpoint deliberately ignored so a step
          // can move past it.
          cpu_en <= 1'b1;
          state  <= S_HALT;
        end

        S_RUN: begin
          if (!bus.RunSw) begin
            state     <= S_HALT;
            prescaler <= '0;
            halted    <= 1'b1;
          end else if (pulse_due && bp_match && !first_pulse) begin
            state  <= S_BREAK;
            halted <= 1'b1;
            bp_hit <= 1'b1;
          end else if (pulse_due) begin
            cpu_en      <= 1'b1;
            prescaler   <= '0;
            first_pulse <= 1'b0;
          end else begin
            // A prescaler already past a newly lowered RateDiv simply wraps.
            prescaler <= prescaler + DIV_ONE;
          end
        end

        S_BREAK: begin
          if (!bus.RunSw) begin
            state  <= S_HALT;
            bp_hit <= 1'b0;
          end else if (step_edge) begin
            state  <= S_STEP;
            bp_hit <= 1'b0;
          end
        end

        default: begin
          state  <= S_HALT;
          halted <= 1'b1;
          bp_hit <= 1'b0;
        end
      endcase
    end
  end

  assign bus.CpuEn      = cpu_en;
  assign bus.Halted     = halted;
  assign bus.BpHit      = bp_hit;
  assign bus.InstrCount = instr_count;

endmodule
